// File: rtl/rijndael_shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for Rijndael states of NB = 4, 6
// or 8 columns. Direction is chosen per block. A sideband tag rides along
// unchanged. A 2-entry buffer (head + tail) decouples the upstream handshake
// from downstream back-pressure, so in_ready never looks at out_ready.
module rijndael_shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*NB-1:0]    in_data,
  input  logic                in_inv,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic [CNT_W-1:0]    blk_count
);

  localparam int W = 32 * NB;

  // Occupancy encoding of the two-entry buffer.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Only the three Rijndael block widths have defined row offsets.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("rijndael_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("rijndael_shift_rows_pipe: TAG_W must be >= 1");
  end

  // Row rotation amounts; rows 2 and 3 rotate one further for 256-bit blocks.
  function automatic int row_shift(input int r);
    case (r)
      0:       row_shift = 0;
      1:       row_shift = 1;
      2:       row_shift = (NB == 8) ? 3 : 2;
      default: row_shift = (NB == 8) ? 4 : 3;
    endcase
  endfunction

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     data;
  } ent_t;

  // Both directions are pure wiring; a single 2:1 mux picks per block.
  logic [W-1:0] enc_data, dec_data, xf_data;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH      = row_shift(r);
      localparam int ENC_SRC = (c + SH) % NB;
      localparam int DEC_SRC = (c - SH + NB) % NB;
      // Byte 4*c+r sits MSB-first, so column 0 row 0 is the top byte.
      localparam int DST     = W - 8 - 8 * (4 * c + r);
      localparam int ENC_LSB = W - 8 - 8 * (4 * ENC_SRC + r);
      localparam int DEC_LSB = W - 8 - 8 * (4 * DEC_SRC + r);
      assign enc_data[DST +: 8] = in_data[ENC_LSB +: 8];
      assign dec_data[DST +: 8] = in_data[DEC_LSB +: 8];
    end
  end

  assign xf_data = in_inv ? dec_data : enc_data;

  logic [1:0]       state_q, state_d;
  ent_t             head_q, head_d;
  ent_t             tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ent_t             new_ent;
  logic             acc, cmp;

  assign in_ready  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
  assign out_valid = (state_q == ST_ONE)   || (state_q == ST_FULL);
  assign out_data  = head_q.data;
  assign out_tag   = head_q.tag;
  assign blk_count = cnt_q;

  assign acc = in_valid && in_ready;
  assign cmp = out_valid && out_ready;

  always_comb begin
    new_ent.tag  = in_tag;
    new_ent.data = xf_data;
  end

  // Buffer next state: head is always the oldest entry, tail only used when full.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          head_d  = new_ent;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && cmp) begin
          // Head leaves and the new block takes its place.
          head_d = new_ent;
        end else if (acc) begin
          tail_d  = new_ent;
          state_d = ST_FULL;
        end else if (cmp) begin
          // Head keeps its stale value; out_valid low makes it don't-care.
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so the only possible event is a completion.
        if (cmp) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Completed-block counter, free-running wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (cmp) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; reset discards any buffered blocks at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rijndael_shift_rows_pipe.sv
// Scoreboard bench for rijndael_shift_rows_pipe: NB=4 main instance with a
// 4-bit counter, plus NB=6 and NB=8 instances for the wider row offsets.
module tb_rijndael_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // NB=4 instance
  logic         in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [3:0]   in_tag, out_tag, blk_count;

  rijndael_shift_rows_pipe #(.NB(4), .TAG_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .blk_count(blk_count)
  );

  // NB=6 instance
  logic         d6_in_valid, d6_in_ready, d6_in_inv, d6_out_valid;
  logic [191:0] d6_in_data, d6_out_data;
  logic [3:0]   d6_in_tag, d6_out_tag;
  logic [15:0]  d6_blk_count;

  rijndael_shift_rows_pipe #(.NB(6), .TAG_W(4), .CNT_W(16)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d6_in_valid), .in_ready(d6_in_ready), .in_data(d6_in_data),
    .in_inv(d6_in_inv), .in_tag(d6_in_tag),
    .out_valid(d6_out_valid), .out_ready(1'b1), .out_data(d6_out_data),
    .out_tag(d6_out_tag), .blk_count(d6_blk_count)
  );

  // NB=8 instance
  logic         d8_in_valid, d8_in_ready, d8_in_inv, d8_out_valid;
  logic [255:0] d8_in_data, d8_out_data;
  logic [3:0]   d8_in_tag, d8_out_tag;
  logic [15:0]  d8_blk_count;

  rijndael_shift_rows_pipe #(.NB(8), .TAG_W(4), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready), .in_data(d8_in_data),
    .in_inv(d8_in_inv), .in_tag(d8_in_tag),
    .out_valid(d8_out_valid), .out_ready(1'b1), .out_data(d8_out_data),
    .out_tag(d8_out_tag), .blk_count(d8_blk_count)
  );

  typedef struct packed {
    logic [3:0]   tag;
    logic [127:0] data;
  } sb_t;

  sb_t        q[$];
  logic [3:0] exp_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference ShiftRows straight from the row/column definition; data is
  // right-aligned in 256 bits, using the low 32*nb bits.
  function automatic logic [255:0] model(input int nb, input logic [255:0] d, input logic inv);
    logic [255:0] o;
    int w, s, src;
    o = '0;
    w = 32 * nb;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (r == 0)      s = 0;
        else if (r == 1) s = 1;
        else if (r == 2) s = (nb == 8) ? 3 : 2;
        else             s = (nb == 8) ? 4 : 3;
        src = inv ? ((c - s + nb) % nb) : ((c + s) % nb);
        o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] model4(input logic [127:0] d, input logic inv);
    logic [255:0] t;
    t = model(4, {128'b0, d}, inv);
    return t[127:0];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Set main-instance inputs just after the falling edge, then settle.
  task automatic drive(input logic v, input logic inv, input logic [127:0] d,
                       input logic [3:0] t, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_inv    = inv;
    in_data   = d;
    in_tag    = t;
    out_ready = ordy;
    #1;
  endtask

  // Advance one rising edge, updating the scoreboard from the model's own
  // view of occupancy.
  task automatic edge_step();
    logic acc, cmp;
    sb_t  e;
    acc = in_valid && (q.size() < 2);
    cmp = out_ready && (q.size() > 0);
    @(posedge clk);
    if (cmp) begin
      q.delete(0);
      exp_cnt = exp_cnt + 4'd1;
    end
    if (acc) begin
      e.tag  = in_tag;
      e.data = model4(in_data, in_inv);
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_inv = 0; in_data = '0; in_tag = '0; out_ready = 0;
    d6_in_valid = 0; d6_in_inv = 0; d6_in_data = '0; d6_in_tag = '0;
    d8_in_valid = 0; d8_in_inv = 0; d8_in_data = '0; d8_in_tag = '0;
    q.delete();
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== 128'b0) begin n_bad++; $display("FAIL rst_out_data: got %h exp 0", out_data); end
    n_cmp++; if (out_tag !== 4'b0)    begin n_bad++; $display("FAIL rst_out_tag: got %h exp 0", out_tag); end
    n_cmp++; if (blk_count !== 4'b0)  begin n_bad++; $display("FAIL rst_blk_count: got %0d exp 0", blk_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(1, 0, 128'h000102030405060708090a0b0c0d0e0f, 4'h5, 1);
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle: got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid); end
    edge_step();
    drive(0, 0, '0, 4'h0, 1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b exp 1", out_valid); end
    n_cmp++; if (out_data !== 128'h00050a0f04090e03080d02070c01060b) begin
      n_bad++; $display("FAIL basic_data: got %h exp 00050a0f04090e03080d02070c01060b", out_data); end
    n_cmp++; if (q.size() != 1 || out_tag !== q[0].tag) begin
      n_bad++; $display("FAIL basic_tag: got %h exp 5", out_tag); end
    edge_step();
    drive(0, 0, '0, 4'h0, 1);
    n_cmp++; if (blk_count !== exp_cnt || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_count: got cnt=%0d vld=%b exp cnt=%0d vld=0", blk_count, out_valid, exp_cnt); end
  endtask

  task automatic test_fips();
    drive(1, 0, 128'hd42711aee0bf98f1b8b45de51e415230, 4'h1, 1);
    edge_step();
    drive(1, 1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 4'h2, 1);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fips_ready: got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
      n_bad++; $display("FAIL fips_enc: got %h exp d4bf5d30e0b452aeb84111f11e2798e5", out_data); end
    edge_step();
    drive(0, 0, '0, 4'h0, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 128'hd42711aee0bf98f1b8b45de51e415230 || out_tag !== 4'h2) begin
      n_bad++; $display("FAIL fips_dec: got %h tag %h exp d42711aee0bf98f1b8b45de51e415230 tag 2", out_data, out_tag); end
    edge_step();
  endtask

  task automatic test_backpressure();
    logic [127:0] d3;
    logic         pend;
    int           seen_tag[$];
    int           seen_cyc[$];
    d3 = rnd128();
    drive(1, 0, rnd128(), 4'h1, 0);
    edge_step();
    drive(1, 0, rnd128(), 4'h2, 0);
    n_cmp++; if (in_ready !== 1'b1 || out_tag !== 4'h1) begin
      n_bad++; $display("FAIL bp_one: got rdy=%b tag=%h exp rdy=1 tag=1", in_ready, out_tag); end
    edge_step();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, d3, 4'h3, 0);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b exp 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_tag !== 4'h1 || out_data !== q[0].data) begin
        n_bad++; $display("FAIL bp_hold: got tag %h data %h exp tag 1 data %h", out_tag, out_data, q[0].data); end
      edge_step();
    end
    pend = 1'b1;
    for (int i = 0; i < 8 && (pend || q.size() > 0); i++) begin
      drive(pend, 0, d3, 4'h3, 1);
      n_cmp++; if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
        n_bad++; $display("FAIL bp_flags: got rdy=%b vld=%b exp rdy=%b vld=%b",
                          in_ready, out_valid, q.size() < 2, q.size() > 0); end
      if (q.size() > 0) begin
        n_cmp++; if (out_tag !== q[0].tag || out_data !== q[0].data) begin
          n_bad++; $display("FAIL bp_drain: got tag %h exp tag %h", out_tag, q[0].tag); end
        seen_tag.push_back(int'(out_tag));
        seen_cyc.push_back(i);
      end
      if (pend && q.size() < 2) pend = 1'b0;
      edge_step();
    end
    n_cmp++; if (seen_tag.size() != 3 || seen_tag[0] != 1 || seen_tag[1] != 2 || seen_tag[2] != 3
                 || seen_cyc[2] - seen_cyc[0] != 2) begin
      n_bad++; $display("FAIL bp_order: got %0d outputs exp tags 1,2,3 on consecutive cycles", seen_tag.size()); end
  endtask

  task automatic test_alternate();
    int bubbles;
    bubbles = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1, i[0], rnd128(), i[3:0], 1);
      else       drive(0, 0, '0, 4'h0, 1);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL alt_ready: got %b exp 1 at %0d", in_ready, i); end
      if (i > 0) begin
        if (out_valid !== 1'b1) bubbles++;
        n_cmp++; if (q.size() == 0 || out_data !== q[0].data || out_tag !== q[0].tag) begin
          n_bad++; $display("FAIL alt_data: got %h tag %h at %0d", out_data, out_tag, i); end
      end
      edge_step();
    end
    n_cmp++; if (bubbles != 0) begin n_bad++; $display("FAIL alt_bubbles: got %0d exp 0", bubbles); end
    drive(0, 0, '0, 4'h0, 1);
    n_cmp++; if (blk_count !== exp_cnt) begin
      n_bad++; $display("FAIL alt_count: got %0d exp %0d", blk_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, rnd128(), 4'ha, 0);
    edge_step();
    drive(1, 1, rnd128(), 4'hb, 0);
    edge_step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_flags: got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready); end
    n_cmp++; if (blk_count !== 4'd0 || out_data !== 128'b0) begin
      n_bad++; $display("FAIL rstmid_state: got cnt=%0d data=%h exp 0", blk_count, out_data); end
    q.delete();
    exp_cnt = '0;
    @(negedge clk);
    in_valid = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 18; i++) begin
      if (i < 17) drive(1, 0, rnd128(), i[3:0], 1);
      else        drive(0, 0, '0, 4'h0, 1);
      if (i > 0) begin
        n_cmp++; if (q.size() == 0 || out_data !== q[0].data) begin
          n_bad++; $display("FAIL wrap_data: got %h at %0d", out_data, i); end
      end
      edge_step();
    end
    drive(0, 0, '0, 4'h0, 1);
    n_cmp++; if (blk_count !== 4'd1 || exp_cnt !== 4'd1) begin
      n_bad++; $display("FAIL wrap_count: got %0d exp 1", blk_count); end
  endtask

  task automatic test_nb68();
    logic [255:0] exp8, exp6;
    @(negedge clk);
    for (int b = 0; b < 32; b++) d8_in_data[255-8*b -: 8] = b[7:0];
    for (int b = 0; b < 24; b++) d6_in_data[191-8*b -: 8] = b[7:0];
    d8_in_valid = 1; d8_in_inv = 0; d8_in_tag = 4'h8;
    d6_in_valid = 1; d6_in_inv = 0; d6_in_tag = 4'h6;
    exp8 = model(8, d8_in_data, 1'b0);
    exp6 = model(6, {64'b0, d6_in_data}, 1'b0);
    @(negedge clk);
    d8_in_valid = 0; d6_in_valid = 0;
    #1;
    n_cmp++; if (d8_out_valid !== 1'b1 || d8_out_data !== exp8 || d8_out_tag !== 4'h8) begin
      n_bad++; $display("FAIL nb8_data: got %h exp %h", d8_out_data, exp8); end
    n_cmp++; if (d8_out_data[255-16 -: 8] !== 8'h0e || d8_out_data[255-24 -: 8] !== 8'h13) begin
      n_bad++; $display("FAIL nb8_rows: got %h %h exp 0e 13", d8_out_data[255-16 -: 8], d8_out_data[255-24 -: 8]); end
    n_cmp++; if (d6_out_valid !== 1'b1 || d6_out_data !== exp6[191:0] || d6_out_tag !== 4'h6) begin
      n_bad++; $display("FAIL nb6_data: got %h exp %h", d6_out_data, exp6[191:0]); end
    n_cmp++; if (d6_out_data[191-16 -: 8] !== 8'h0a || d6_out_data[191-24 -: 8] !== 8'h0f) begin
      n_bad++; $display("FAIL nb6_rows: got %h %h exp 0a 0f", d6_out_data[191-16 -: 8], d6_out_data[191-24 -: 8]); end
    // Inverse on the wide block must restore the byte ramp.
    d8_in_data = exp8; d8_in_inv = 1; d8_in_valid = 1;
    @(negedge clk);
    d8_in_valid = 0;
    #1;
    for (int b = 0; b < 32; b++) exp8[255-8*b -: 8] = b[7:0];
    n_cmp++; if (d8_out_valid !== 1'b1 || d8_out_data !== exp8) begin
      n_bad++; $display("FAIL nb8_inv: got %h exp %h", d8_out_data, exp8); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_fips();
    test_backpressure();
    test_alternate();
    test_reset_mid();
    test_wrap();
    test_nb68();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
